// File: rtl/apb_pkg.sv
// Shared types and constants for the APB initiator and the UART receiver register map.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    // Receiver register map
    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_ERROR   = 3'd1;
    localparam logic [2:0] ADDR_BITP_LO = 3'd2;
    localparam logic [2:0] ADDR_BITP_HI = 3'd3;
    localparam logic [2:0] ADDR_DSIZE   = 3'd4;
    localparam logic [2:0] ADDR_RXDATA  = 3'd6;

    // pslverr encodings
    localparam logic PSLVERR_OK  = 1'b0;
    localparam logic PSLVERR_ERR = 1'b1;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the ACCESS phase; saturates at TIMEOUT_CYCLES-1 and flags it.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    assign tc = (count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!n_rst || clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB initiator: command in, SETUP/ACCESS sequencing, response out.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 3,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_t state, state_next;
    logic       timer_clr, timer_en, timer_tc;

    assign cmd_ready = (state == IDLE);

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk  (clk),
        .n_rst(n_rst),
        .clr  (timer_clr),
        .en   (timer_en),
        .tc   (timer_tc)
    );

    always_comb begin
        state_next = state;
        timer_clr  = 1'b0;
        timer_en   = 1'b0;
        case (state)
            IDLE:    if (cmd_valid) state_next = SETUP;
            SETUP: begin
                state_next = ACCESS;
                timer_clr  = 1'b1;
            end
            ACCESS: begin
                if (pready || timer_tc) state_next = RESP;
                else                    timer_en   = 1'b1;
            end
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr  <= cmd_addr;
                        pwrite <= cmd_write;
                        pwdata <= cmd_wdata;
                        psel   <= 1'b1;
                    end
                end
                SETUP: penable <= 1'b1;
                ACCESS: begin
                    if (pready) begin
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                    end else if (timer_tc) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                    end
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: vector table plus backpressure and mid-transfer reset sequences.
module tb_apb_master;
    import apb_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err, rsp_timeout;
    logic       psel, penable, pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata, prdata;
    logic       pready, pslverr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_master #(
        .ADDR_W(3),
        .DATA_W(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .paddr      (paddr),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] wdata;
        int         waits;     // 255 = slave never ready
        logic [7:0] prd;
        logic       slverr;
        logic [7:0] exp_rdata;
        logic       exp_err;
        logic       exp_to;
        int         exp_acc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int  acc;
        int  t;
        bit  stable;
        chk($sformatf("v%0d cmd_ready idle", idx), cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        rsp_ready = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;
        chk($sformatf("v%0d setup psel/penable", idx), {psel, penable}, 2'b10);
        chk($sformatf("v%0d setup paddr/pwrite/pwdata", idx), {paddr, pwrite, pwdata},
            {v.addr, v.wr, v.wdata});
        acc    = 0;
        t      = 1;
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            t++;
            if (!(psel && penable)) break;
            if (paddr !== v.addr || pwrite !== v.wr || pwdata !== v.wdata) stable = 1'b0;
            pready  = (acc == v.waits);
            prdata  = pready ? v.prd : ~v.prd;
            pslverr = pready ? v.slverr : ~v.slverr;
            acc++;
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 8'hEE;
        chk($sformatf("v%0d access cycles", idx), acc, v.exp_acc);
        chk($sformatf("v%0d rsp latency", idx), t, 2 + v.exp_acc);
        chk($sformatf("v%0d apb stable", idx), stable, 1);
        chk($sformatf("v%0d rsp valid, psel low", idx), {rsp_valid, psel, penable}, 3'b100);
        chk($sformatf("v%0d rsp fields", idx), {rsp_rdata, rsp_err, rsp_timeout},
            {v.exp_rdata, v.exp_err, v.exp_to});
        cyc();
        chk($sformatf("v%0d back to idle", idx), {rsp_valid, cmd_ready, psel}, 3'b010);
    endtask

    initial begin
        vecs[0] = '{1'b1, ADDR_BITP_LO, 8'h0A, 0,   8'h99, PSLVERR_OK,  8'h00, 1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, ADDR_RXDATA,  8'h00, 0,   8'h5A, PSLVERR_OK,  8'h5A, 1'b0, 1'b0, 1};
        vecs[2] = '{1'b1, ADDR_STATUS,  8'h3C, 0,   8'h77, PSLVERR_ERR, 8'h00, 1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, ADDR_DSIZE,   8'h00, 3,   8'h08, PSLVERR_OK,  8'h08, 1'b0, 1'b0, 4};
        vecs[4] = '{1'b0, ADDR_ERROR,   8'h00, 255, 8'h77, PSLVERR_OK,  8'h00, 1'b1, 1'b1, 16};
        vecs[5] = '{1'b0, ADDR_BITP_HI, 8'h00, 2,   8'h33, PSLVERR_ERR, 8'h33, 1'b1, 1'b0, 3};
        vecs[6] = '{1'b1, 3'd5,         8'hC3, 1,   8'hFF, PSLVERR_OK,  8'h00, 1'b0, 1'b0, 2};

        n_rst     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        cyc();
        cyc();
        chk("reset apb outputs", {psel, penable, paddr, pwrite, pwdata}, '0);
        chk("reset rsp outputs", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, '0);
        chk("reset cmd_ready", cmd_ready, 1);
        n_rst = 1'b1;
        cyc();

        for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

        // Response backpressure with a competing command
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = ADDR_RXDATA;
        cyc();
        cmd_addr = ADDR_BITP_LO;
        cyc();
        pready = 1'b1;
        prdata = 8'h11;
        cyc();
        pready = 1'b0;
        prdata = 8'h00;
        chk("bp rsp_valid", rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("bp hold %0d", i), {rsp_valid, rsp_rdata, rsp_err, rsp_timeout},
                {1'b1, 8'h11, 1'b0, 1'b0});
            chk($sformatf("bp no cmd %0d", i), {cmd_ready, psel, penable}, 3'b000);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        cyc();
        chk("bp release", {rsp_valid, cmd_ready, psel}, 3'b010);

        // Reset while in ACCESS with the slave stalling
        cmd_valid = 1'b1;
        cmd_addr  = ADDR_DSIZE;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        chk("pre-reset access", {psel, penable}, 2'b11);
        n_rst = 1'b0;
        cyc();
        chk("mid reset apb low", {psel, penable, rsp_valid}, 3'b000);
        chk("mid reset cmd_ready", cmd_ready, 1);
        chk("mid reset paddr", paddr, 0);
        n_rst = 1'b1;
        cyc();
        run_txn(vecs[1], 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

endmodule
